// File: rtl/rsa_exp_ctrl.sv
`default_nettype none
// ============================================================================
// rsa_exp_ctrl : right-to-left square-and-multiply sequencer for y^d mod N,
//                driving an external modular-product unit one op at a time.
// Revision     : 1.0
// ============================================================================
module rsa_exp_ctrl #(
   parameter int W = 256
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_start,
   input  logic [W-1:0] i_y,
   input  logic [W-1:0] i_d,
   input  logic [W-1:0] i_N,
   output logic [W-1:0] o_result,
   output logic         o_done,
   output logic         o_busy,
   output logic         mm_start,
   output logic [W:0]   mm_a,
   output logic [W:0]   mm_b,
   output logic [W:0]   mm_N,
   output logic [10:0]  mm_k,
   input  logic [W:0]   mm_result,
   input  logic         mm_done
);

   localparam int            IW   = (W > 1) ? $clog2(W) : 1;
   localparam logic [IW-1:0] LAST = IW'(W - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ISSUE_MUL = 3'd1,
      S_WAIT_MUL  = 3'd2,
      S_ISSUE_SQR = 3'd3,
      S_WAIT_SQR  = 3'd4,
      S_DONE      = 3'd5
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    m_q, m_d;
   logic [W-1:0]    t_q, t_d;
   logic [W-1:0]    dr_q, dr_d;
   logic [W-1:0]    nr_q, nr_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [W-1:0]    result_q, result_d;
   logic            done_q, done_d;
   logic            busy_q, busy_d;
   logic            start_q, start_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    w_prod;
   logic [IW-1:0]   w_nidx;
   logic            w_unused;

   assign w_prod   = mm_result[W-1:0];
   assign w_unused = mm_result[W];
   assign w_nidx   = idx_q + 1'b1;

   // The next operation is chosen in the same cycle the previous one
   // completes, so every operation costs exactly latency + 1 cycles.
   always_comb begin
      state_d  = state_q;
      m_d      = m_q;
      t_d      = t_q;
      dr_d     = dr_q;
      nr_d     = nr_q;
      idx_d    = idx_q;
      result_d = result_q;
      busy_d   = busy_q;
      a_d      = a_q;
      b_d      = b_q;
      done_d   = 1'b0;
      start_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               t_d     = i_y;
               dr_d    = i_d;
               nr_d    = i_N;
               m_d     = W'(1);
               idx_d   = '0;
               busy_d  = 1'b1;
               start_d = 1'b1;
               b_d     = i_y;
               if (i_d[0]) begin
                  state_d = S_ISSUE_MUL;
                  a_d     = W'(1);
               end else begin
                  state_d = S_ISSUE_SQR;
                  a_d     = i_y;
               end
            end
         end
         S_ISSUE_MUL: state_d = S_WAIT_MUL;
         S_ISSUE_SQR: state_d = S_WAIT_SQR;
         S_WAIT_MUL: begin
            if (mm_done) begin
               m_d     = w_prod;
               state_d = S_ISSUE_SQR;
               start_d = 1'b1;
               a_d     = t_q;
               b_d     = t_q;
            end
         end
         S_WAIT_SQR: begin
            if (mm_done) begin
               t_d = w_prod;
               if (idx_q == LAST) begin
                  state_d  = S_DONE;
                  done_d   = 1'b1;
                  result_d = m_q;
               end else begin
                  idx_d   = w_nidx;
                  start_d = 1'b1;
                  b_d     = w_prod;
                  if (dr_q[w_nidx]) begin
                     state_d = S_ISSUE_MUL;
                     a_d     = m_q;
                  end else begin
                     state_d = S_ISSUE_SQR;
                     a_d     = w_prod;
                  end
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         m_q      <= '0;
         t_q      <= '0;
         dr_q     <= '0;
         nr_q     <= '0;
         idx_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         start_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
      end else begin
         state_q  <= state_d;
         m_q      <= m_d;
         t_q      <= t_d;
         dr_q     <= dr_d;
         nr_q     <= nr_d;
         idx_q    <= idx_d;
         result_q <= result_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         start_q  <= start_d;
         a_q      <= a_d;
         b_q      <= b_d;
      end
   end

   assign o_result = result_q;
   assign o_done   = done_q;
   assign o_busy   = busy_q;
   assign mm_start = start_q;
   assign mm_a     = {1'b0, a_q};
   assign mm_b     = {1'b0, b_q};
   assign mm_N     = {1'b0, nr_q};
   assign mm_k     = 11'(W);

endmodule
`default_nettype wire

// File: tb/tb_rsa_exp_ctrl.sv
`default_nettype none
// ============================================================================
// tb_rsa_exp_ctrl : directed bench for rsa_exp_ctrl with behavioural
//                   modular-product models (W=8 and W=12 instances).
// Revision        : 1.0
// ============================================================================
module tb_rsa_exp_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- instance A : W = 8 ----------------
   logic        a_start = 1'b0;
   logic [7:0]  a_y = '0, a_d = '0, a_n = '0;
   logic [7:0]  a_res;
   logic        a_done, a_busy, a_mms, a_mmd;
   logic [8:0]  a_ma, a_mb, a_mn, a_mmr;
   logic [10:0] a_mk;
   logic        a_extra = 1'b0;
   logic        a_mdm;
   logic [8:0]  a_prod;
   logic [26:0] a_cap;
   int          a_cnt, a_lat = 3, a_nlat = 3;
   bit          a_rand = 1'b0;
   int          a_nstart = 0, a_neq = 0, a_ndone = 0, a_viol = 0;
   logic        a_prev = 1'b0;

   rsa_exp_ctrl #(.W(8)) u_a (
      .clk(clk), .rst_n(rst_n), .i_start(a_start), .i_y(a_y), .i_d(a_d), .i_N(a_n),
      .o_result(a_res), .o_done(a_done), .o_busy(a_busy), .mm_start(a_mms),
      .mm_a(a_ma), .mm_b(a_mb), .mm_N(a_mn), .mm_k(a_mk),
      .mm_result(a_mmr), .mm_done(a_mmd)
   );

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_cnt <= 0;
         a_mdm <= 1'b0;
      end else begin
         a_mdm <= 1'b0;
         if (a_mms) begin
            a_prod <= {1'b1, 8'((int'(a_ma) * int'(a_mb)) % int'(a_mn))};
            a_cap  <= {a_ma, a_mb, a_mn};
            if (a_nlat == 1) begin
               a_mdm <= 1'b1;
               a_cnt <= 0;
            end else begin
               a_cnt <= a_nlat - 1;
            end
         end else if (a_cnt != 0) begin
            a_cnt <= a_cnt - 1;
            if (a_cnt == 1) a_mdm <= 1'b1;
         end
      end
   end
   assign a_mmr = a_prod;
   assign a_mmd = a_mdm | a_extra;

   // Protocol monitor: pulse counts, back-to-back/while-waiting starts, operand stability.
   always @(negedge clk) begin
      a_nlat   <= a_rand ? int'($urandom_range(1, 7)) : a_lat;
      a_nstart <= a_nstart + (a_mms ? 1 : 0);
      a_neq    <= a_neq + ((a_mms && a_ma != a_mb) ? 1 : 0);
      a_ndone  <= a_ndone + (a_done ? 1 : 0);
      a_viol   <= a_viol
                + ((a_mms && (a_prev || a_cnt != 0 || a_mdm)) ? 1 : 0)
                + ((!a_mms && (a_cnt != 0 || a_mdm) && {a_ma, a_mb, a_mn} != a_cap) ? 1 : 0);
      a_prev   <= a_mms;
   end

   // ---------------- instance B : W = 12 ----------------
   logic        b_start = 1'b0;
   logic [11:0] b_y = '0, b_d = '0, b_n = '0;
   logic [11:0] b_res;
   logic        b_done, b_busy, b_mms, b_mdm;
   logic [12:0] b_ma, b_mb, b_mn, b_prod;
   logic [10:0] b_mk;
   int          b_cnt;

   rsa_exp_ctrl #(.W(12)) u_b (
      .clk(clk), .rst_n(rst_n), .i_start(b_start), .i_y(b_y), .i_d(b_d), .i_N(b_n),
      .o_result(b_res), .o_done(b_done), .o_busy(b_busy), .mm_start(b_mms),
      .mm_a(b_ma), .mm_b(b_mb), .mm_N(b_mn), .mm_k(b_mk),
      .mm_result(b_prod), .mm_done(b_mdm)
   );

   // Fixed latency L = 2
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_cnt <= 0;
         b_mdm <= 1'b0;
      end else begin
         b_mdm <= 1'b0;
         if (b_mms) begin
            b_prod <= {1'b1, 12'((int'(b_ma) * int'(b_mb)) % int'(b_mn))};
            b_cnt  <= 1;
         end else if (b_cnt != 0) begin
            b_cnt <= b_cnt - 1;
            if (b_cnt == 1) b_mdm <= 1'b1;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic run_a(input logic [7:0] y, input logic [7:0] d, input logic [7:0] n,
                        input bit hammer, output int ncyc, output int nst,
                        output int neq, output int viol, output int ndn);
      int c0, s0, q0, v0, d0;
      bit got;
      step();
      a_y = y; a_d = d; a_n = n; a_start = 1'b1;
      c0 = cyc; s0 = a_nstart; q0 = a_neq; v0 = a_viol; d0 = a_ndone;
      got = 1'b0;
      for (int k = 0; k < 3000 && !got; k++) begin
         step();
         if (hammer) begin
            a_y = 8'($urandom); a_d = 8'($urandom); a_n = 8'($urandom);
         end else begin
            a_start = 1'b0;
         end
         if (a_done) begin
            got = 1'b1;
            a_start = 1'b0;
         end
      end
      chk("a_done_seen", 64'(got), 64'd1);
      ncyc = cyc - c0;
      nst  = a_nstart - s0;
      neq  = a_neq - q0;
      viol = a_viol - v0;
      ndn  = a_ndone - d0;
   endtask

   task automatic run_b(input logic [11:0] y, input logic [11:0] d, input logic [11:0] n);
      bit got;
      step();
      b_y = y; b_d = d; b_n = n; b_start = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 3000 && !got; k++) begin
         step();
         b_start = 1'b0;
         if (b_done) got = 1'b1;
      end
      chk("b_done_seen", 64'(got), 64'd1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int ncyc, nst, neq, viol, ndn, s0, d0;
      bit hit;

      step(); step(); step();
      chk("rst_result", 64'(a_res), 64'd0);
      chk("rst_done",   64'(a_done), 64'd0);
      chk("rst_busy",   64'(a_busy), 64'd0);
      chk("rst_mmstart", 64'(a_mms), 64'd0);
      chk("mm_k_w8",    64'(a_mk), 64'd8);
      rst_n = 1'b1;
      step();

      // 3^5 mod 7 with L=3: 8 squarings + 2 multiplies, done at 10*4+1
      run_a(8'd3, 8'd5, 8'd7, 1'b0, ncyc, nst, neq, viol, ndn);
      chk("t1_result", 64'(a_res), 64'd5);
      chk("t1_nstart", 64'(nst), 64'd10);
      chk("t1_done_cycle", 64'(ncyc), 64'd41);
      chk("t1_protocol", 64'(viol), 64'd0);
      step();
      chk("t1_busy_after", 64'(a_busy), 64'd0);

      run_b(12'd65, 12'd17, 12'd3233);
      chk("rsa_encrypt", 64'(b_res), 64'd2790);
      run_b(12'd2790, 12'd2753, 12'd3233);
      chk("rsa_decrypt", 64'(b_res), 64'd65);

      run_a(8'd5, 8'd0, 8'd11, 1'b0, ncyc, nst, neq, viol, ndn);
      chk("d0_result", 64'(a_res), 64'd1);
      chk("d0_nstart", 64'(nst), 64'd8);
      chk("d0_all_squares", 64'(neq), 64'd0);

      // Random latency per operation, then stray mm_done pulses in IDLE
      a_rand = 1'b1;
      run_a(8'd3, 8'd5, 8'd7, 1'b0, ncyc, nst, neq, viol, ndn);
      chk("rl_result", 64'(a_res), 64'd5);
      chk("rl_protocol", 64'(viol), 64'd0);
      a_rand = 1'b0;
      s0 = a_nstart;
      for (int k = 0; k < 6; k++) begin
         step();
         a_extra = k[0];
      end
      step();
      a_extra = 1'b0;
      step();
      chk("idle_mmdone_busy", 64'(a_busy), 64'd0);
      chk("idle_mmdone_result", 64'(a_res), 64'd5);
      chk("idle_mmdone_nstart", 64'(a_nstart - s0), 64'd0);

      // i_start held high (with changing operands) for the whole command; 2^5 mod 7 = 4
      d0 = a_ndone;
      run_a(8'd2, 8'd5, 8'd7, 1'b1, ncyc, nst, neq, viol, ndn);
      chk("hammer_result", 64'(a_res), 64'd4);
      chk("hammer_nstart", 64'(nst), 64'd10);
      s0 = a_nstart;
      for (int k = 0; k < 4; k++) step();
      chk("hammer_one_done", 64'(a_ndone - d0), 64'd1);
      chk("hammer_result_held", 64'(a_res), 64'd4);
      chk("hammer_no_restart", 64'(a_nstart - s0), 64'd0);

      // Reset during the 4th squaring wait (6th operation for d=5)
      step();
      a_y = 8'd3; a_d = 8'd5; a_n = 8'd7; a_start = 1'b1;
      s0 = a_nstart;
      hit = 1'b0;
      for (int k = 0; k < 500 && !hit; k++) begin
         step();
         a_start = 1'b0;
         if (a_nstart - s0 >= 6) hit = 1'b1;
      end
      chk("rst_mid_reached", 64'(hit), 64'd1);
      step();
      rst_n = 1'b0;
      #1;
      chk("rst_mid_busy",   64'(a_busy), 64'd0);
      chk("rst_mid_result", 64'(a_res), 64'd0);
      chk("rst_mid_mm_a",   64'(a_ma), 64'd0);
      chk("rst_mid_mmstart", 64'(a_mms), 64'd0);
      step(); step();
      rst_n = 1'b1;
      step();
      run_a(8'd3, 8'd5, 8'd7, 1'b0, ncyc, nst, neq, viol, ndn);
      chk("post_rst_result", 64'(a_res), 64'd5);
      chk("post_rst_nstart", 64'(nst), 64'd10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
